rfphoenix_trace_buffer: RTL and testbench

Branch-trace capture FIFO for the rfPhoenix core. The commit stage pushes trace addresses (branch targets, exception vectors) into it. The vector ALU lanes read the oldest entry through `trace_dout`, `trace_empty`, `trace_valid` and `trace_count`, and the trace-read instruction pops it on retire. The block is the writer/owner end of the trace interface that the ALU consumes.

---
 rtl/rfphoenix_trace_buffer_if.sv | 29 ++
 rtl/rfphoenix_trace_buffer.sv | 158 +++++++++++++++
 tb/tb_rfphoenix_trace_buffer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rfphoenix_trace_buffer_if.sv
// Trace interface between the capture buffer (master, owner of the stored
// entries) and its consumers (slave: commit-side pushers and ALU readers).
interface rfphoenix_trace_buffer_if #(
  parameter int AWID = 32
);
  logic            trace_en;
  logic            trace_mode;
  logic            trace_dedup;
  logic            trace_clr;
  logic            trace_wr;
  logic [AWID-1:0] trace_adr;
  logic            trace_rd;
  logic [AWID-1:0] trace_dout;
  logic            trace_empty;
  logic            trace_valid;
  logic [10:0]     trace_count;
  logic            trace_full;
  logic            trace_ovf;

  modport master (
    input  trace_en, trace_mode, trace_dedup, trace_clr, trace_wr, trace_adr, trace_rd,
    output trace_dout, trace_empty, trace_valid, trace_count, trace_full, trace_ovf
  );

  modport slave (
    output trace_en, trace_mode, trace_dedup, trace_clr, trace_wr, trace_adr, trace_rd,
    input  trace_dout, trace_empty, trace_valid, trace_count, trace_full, trace_ovf
  );
endinterface

// File: rtl/rfphoenix_trace_buffer.sv
// Branch-trace capture FIFO for rfPhoenix. Commit pushes trace addresses,
// readers see the oldest entry on trace_dout once the read FSM has fetched it.
//
// Read FSM states:
//   state   | meaning
//   S_EMPTY | no entries, trace_valid low
//   S_FETCH | rptr presented to the RAM, trace_dout loads at this edge
//   S_VALID | trace_dout holds the current head, trace_valid high
module rfphoenix_trace_buffer #(
  parameter int DEPTH = 1024,
  parameter int AWID  = 32
) (
  input logic                      clk,
  input logic                      rst,
  rfphoenix_trace_buffer_if.master trc
);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] DEPTH_C = 11'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_VALID} state_t;

  state_t          state;
  logic [AWID-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [10:0]     cnt;
  logic [10:0]     cnt_nxt;
  logic [AWID-1:0] last_adr;
  logic            last_vld;
  logic [AWID-1:0] dout_q;
  logic            valid_q;
  logic            empty_q;
  logic            full_q;
  logic            ovf_q;

  logic is_full;
  logic dup;
  logic wr_ok;
  logic rd_ok;
  logic push_wr;
  logic overwrite;
  logic drop;
  logic ram_we;

  assign is_full   = (cnt == DEPTH_C);
  assign dup       = trc.trace_dedup & last_vld & (trc.trace_adr == last_adr);
  assign wr_ok     = trc.trace_wr & trc.trace_en & ~dup;
  assign rd_ok     = trc.trace_rd & valid_q;
  // A push at full still writes when a pop frees the slot or wrap mode overwrites.
  assign push_wr   = wr_ok & (~is_full | rd_ok | trc.trace_mode);
  assign overwrite = wr_ok & is_full & ~rd_ok & trc.trace_mode;
  assign drop      = wr_ok & is_full & ~rd_ok & ~trc.trace_mode;
  // Clear and reset discard any same-cycle push, including the RAM write.
  assign ram_we    = push_wr & ~trc.trace_clr & ~rst;

  // Next entry count; overwrite and push+pop both leave it unchanged.
  always_comb begin
    cnt_nxt = cnt;
    if (push_wr && !rd_ok && !overwrite) begin
      cnt_nxt = cnt + 11'd1;
    end else if (rd_ok && !push_wr) begin
      cnt_nxt = cnt - 11'd1;
    end
  end

  // Trace storage write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wptr] <= trc.trace_adr;
    end
  end

  // Pointers, count, status flags and dedup history.
  always_ff @(posedge clk) begin
    if (rst || trc.trace_clr) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      last_vld <= 1'b0;
      if (rst) begin
        last_adr <= '0;
      end
    end else begin
      if (push_wr) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok || overwrite) begin
        rptr <= rptr + PTR_ONE;
      end
      cnt     <= cnt_nxt;
      empty_q <= (cnt_nxt == 11'd0);
      full_q  <= (cnt_nxt == DEPTH_C);
      if (overwrite || drop) begin
        ovf_q <= 1'b1;
      end
      if (wr_ok) begin
        last_adr <= trc.trace_adr;
        last_vld <= 1'b1;
      end
    end
  end

  // Read FSM: fetches the head into trace_dout and drives trace_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_EMPTY;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else if (trc.trace_clr) begin
      state   <= S_EMPTY;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          valid_q <= 1'b0;
          if (cnt_nxt != 11'd0) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Write-first: a same-address write this cycle is the fresher head.
          dout_q <= (ram_we && (wptr == rptr)) ? trc.trace_adr : mem[rptr];
          if (overwrite) begin
            state   <= S_FETCH;
            valid_q <= 1'b0;
          end else begin
            state   <= S_VALID;
            valid_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (overwrite) begin
            state   <= S_FETCH;
            valid_q <= 1'b0;
          end else if (rd_ok) begin
            valid_q <= 1'b0;
            state   <= (cnt_nxt == 11'd0) ? S_EMPTY : S_FETCH;
          end
        end
        default: begin
          state   <= S_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign trc.trace_dout  = dout_q;
  assign trc.trace_empty = empty_q;
  assign trc.trace_valid = valid_q;
  assign trc.trace_count = cnt;
  assign trc.trace_full  = full_q;
  assign trc.trace_ovf   = ovf_q;
endmodule

// File: tb/tb_rfphoenix_trace_buffer.sv
// Self-checking bench for rfphoenix_trace_buffer. A queue model holds the
// expected buffer contents; pops are checked against its front.
module tb_rfphoenix_trace_buffer;
  localparam int DEPTH = 1024;
  localparam int AWID  = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rfphoenix_trace_buffer_if #(.AWID(AWID)) trc ();

  rfphoenix_trace_buffer #(.DEPTH(DEPTH), .AWID(AWID)) dut (
    .clk (clk),
    .rst (rst),
    .trc (trc)
  );

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [AWID-1:0] sb[$];
  logic            m_ovf      = 1'b0;
  logic            m_last_vld = 1'b0;
  logic [AWID-1:0] m_last     = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one push strobe.
  function automatic void m_push(input logic [AWID-1:0] a);
    if (!trc.trace_en) return;
    if (trc.trace_dedup && m_last_vld && a == m_last) return;
    m_last     = a;
    m_last_vld = 1'b1;
    if (sb.size() < DEPTH) begin
      sb.push_back(a);
    end else begin
      m_ovf = 1'b1;
      if (trc.trace_mode) begin
        void'(sb.pop_front());
        sb.push_back(a);
      end
    end
  endfunction

  function automatic void m_clear();
    sb.delete();
    m_ovf      = 1'b0;
    m_last_vld = 1'b0;
  endfunction

  task automatic push(input logic [AWID-1:0] a);
    trc.trace_wr  = 1'b1;
    trc.trace_adr = a;
    m_push(a);
    tick();
    trc.trace_wr = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!trc.trace_valid && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(trc.trace_valid), 32'd1);
  endtask

  task automatic pop(input string tag);
    logic [AWID-1:0] e;
    wait_valid(tag);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_dout"}, trc.trace_dout, e);
    trc.trace_rd = 1'b1;
    tick();
    trc.trace_rd = 1'b0;
    chk({tag, "_gap"}, 32'(trc.trace_valid), 32'd0);
    chk({tag, "_empty"}, 32'(trc.trace_empty), 32'(sb.size() == 0));
  endtask

  task automatic push_pop(input string tag, input logic [AWID-1:0] a);
    logic [AWID-1:0] e;
    wait_valid(tag);
    e = sb.pop_front();
    chk({tag, "_dout"}, trc.trace_dout, e);
    m_push(a);
    trc.trace_wr  = 1'b1;
    trc.trace_rd  = 1'b1;
    trc.trace_adr = a;
    tick();
    trc.trace_wr = 1'b0;
    trc.trace_rd = 1'b0;
  endtask

  task automatic clear();
    trc.trace_clr = 1'b1;
    tick();
    trc.trace_clr = 1'b0;
    m_clear();
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(trc.trace_count), 32'(sb.size()));
    chk({tag, "_empty"}, 32'(trc.trace_empty), 32'(sb.size() == 0));
    chk({tag, "_full"},  32'(trc.trace_full),  32'(sb.size() == DEPTH));
    chk({tag, "_ovf"},   32'(trc.trace_ovf),   32'(m_ovf));
  endtask

  task automatic drain(input string tag);
    int n = sb.size();
    for (int i = 0; i < n; i++) pop(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    trc.trace_en    = 1'b1;
    trc.trace_mode  = 1'b0;
    trc.trace_dedup = 1'b0;
    trc.trace_clr   = 1'b0;
    trc.trace_wr    = 1'b0;
    trc.trace_adr   = '0;
    trc.trace_rd    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_dout",  trc.trace_dout, 32'h0);
    chk("rst_valid", 32'(trc.trace_valid), 32'd0);
    chk_status("rst");

    // Three consecutive pushes: head valid two cycles after the first.
    push(32'h100);
    chk("t1_cnt1",   32'(trc.trace_count), 32'd1);
    chk("t1_nvalid", 32'(trc.trace_valid), 32'd0);
    push(32'h200);
    chk("t1_cnt2",   32'(trc.trace_count), 32'd2);
    chk("t1_valid",  32'(trc.trace_valid), 32'd1);
    chk("t1_head",   trc.trace_dout, 32'h100);
    push(32'h300);
    chk("t1_cnt3",   32'(trc.trace_count), 32'd3);
    drain("t1_pop");
    chk_status("t1_end");

    // Dedup suppresses only back-to-back duplicates.
    clear();
    trc.trace_dedup = 1'b1;
    push(32'h40);
    push(32'h40);
    push(32'h44);
    push(32'h40);
    trc.trace_dedup = 1'b0;
    chk("dd_cnt", 32'(trc.trace_count), 32'd3);
    chk_status("dd");
    drain("dd_pop");

    // Push and pop together at cnt=5.
    clear();
    for (int i = 1; i <= 5; i++) push(AWID'(i));
    push_pop("pp5", 32'h6);
    chk("pp5_cnt", 32'(trc.trace_count), 32'd5);
    chk_status("pp5");
    drain("pp5_pop");

    // Stop mode: fill, push+pop at full keeps ovf clear.
    clear();
    trc.trace_mode = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(AWID'(i));
    chk_status("sf_fill");
    push_pop("sf_pp", 32'hAAAA);
    chk("sf_pp_cnt", 32'(trc.trace_count), 32'd1024);
    chk("sf_pp_ovf", 32'(trc.trace_ovf), 32'd0);
    chk_status("sf_pp");

    // Stop mode: DEPTH+1 pushes, last one lost.
    clear();
    for (int i = 0; i <= DEPTH; i++) push(AWID'(i));
    chk("so_cnt", 32'(trc.trace_count), 32'd1024);
    chk("so_ovf", 32'(trc.trace_ovf), 32'd1);
    chk_status("so");
    wait_valid("so_head");
    chk("so_head", trc.trace_dout, 32'h0);

    // Wrap mode: DEPTH+2 pushes, oldest two overwritten.
    clear();
    trc.trace_mode = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) push(AWID'(i));
    chk("wr_cnt", 32'(trc.trace_count), 32'd1024);
    chk_status("wr");
    wait_valid("wr_head");
    chk("wr_head", trc.trace_dout, 32'h2);
    drain("wr_pop");
    trc.trace_mode = 1'b0;
    chk_status("wr_end");

    // Pop while empty is ignored; ovf stays sticky.
    trc.trace_rd = 1'b1;
    tick();
    trc.trace_rd = 1'b0;
    tick();
    chk("pe_valid", 32'(trc.trace_valid), 32'd0);
    chk_status("pe");

    // Clear together with a push at cnt=7, ovf=1.
    for (int i = 0; i < 7; i++) push(AWID'(32'h700 + i));
    chk_status("cw_pre");
    trc.trace_clr = 1'b1;
    trc.trace_wr  = 1'b1;
    trc.trace_adr = 32'hDEAD;
    tick();
    trc.trace_clr = 1'b0;
    trc.trace_wr  = 1'b0;
    m_clear();
    chk("cw_cnt",   32'(trc.trace_count), 32'd0);
    chk("cw_empty", 32'(trc.trace_empty), 32'd1);
    chk("cw_ovf",   32'(trc.trace_ovf),   32'd0);
    chk("cw_valid", 32'(trc.trace_valid), 32'd0);
    repeat (4) tick();
    chk("cw_late_valid", 32'(trc.trace_valid), 32'd0);
    chk_status("cw_late");

    // Reset mid-operation.
    push(32'h11);
    push(32'h22);
    wait_valid("rm");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_clear();
    chk("rm_dout",  trc.trace_dout, 32'h0);
    chk("rm_valid", 32'(trc.trace_valid), 32'd0);
    chk_status("rm");
    push(32'h55);
    pop("rm_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
